// File: rtl/gf180mcu_osu_sc_9t_clkdiv_pkg.sv
// Shared types and sizing helpers for the programmable clock-divider bank.
package gf180mcu_osu_sc_9t_clkdiv_pkg;

  localparam int CFG_DIV_W = 8;
  localparam int MAX_CH    = 16;

  typedef struct packed {
    logic [CFG_DIV_W-1:0] div;
    logic                 inv;
    logic                 en;
  } cfg_t;

  // Channel-select width; a single-channel bank still carries a 1-bit select.
  function automatic int ch_sel_w(input int n_ch);
    return (n_ch <= 1) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_9t_clkdiv_ch.sv
// One divider channel: shadowed config, counter/phase state and a registered
// output. New settings are applied only at a full-period boundary.
module gf180mcu_osu_sc_9t_clkdiv_ch #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rn,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  input  logic             wr_inv,
  input  logic             wr_en,
  output logic             y,
  output logic             busy
);

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic             inv;
    logic             en;
  } ch_cfg_t;

  ch_cfg_t          act_q, act_d;
  ch_cfg_t          shd_q, shd_d;
  logic             pend_q, pend_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             ph_q, ph_d;
  logic             y_q, y_d;
  logic             wrap;
  logic             apply;

  assign wrap  = (cnt_q == act_q.div);
  // A running channel only switches at the end of its high half (ph == 1).
  assign apply = pend_q & (~act_q.en | (wrap & ph_q));

  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    ph_d   = ph_q;
    y_d    = y_q;
    if (apply) begin
      act_d  = shd_q;
      pend_d = 1'b0;
      cnt_d  = '0;
      ph_d   = 1'b0;
      y_d    = shd_q.inv;
    end else if (act_q.en) begin
      if (wrap) begin
        cnt_d = '0;
        ph_d  = ~ph_q;
        y_d   = ~ph_q ^ act_q.inv;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end else begin
      cnt_d = '0;
      ph_d  = 1'b0;
      y_d   = act_q.inv;
    end
    // A write can never coincide with an apply: it needs pend_q == 0.
    if (wr) begin
      shd_d.div = wr_div;
      shd_d.inv = wr_inv;
      shd_d.en  = wr_en;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rn) begin
      act_q  <= '0;
      shd_q  <= '0;
      pend_q <= 1'b0;
      cnt_q  <= '0;
      ph_q   <= 1'b0;
      y_q    <= 1'b0;
    end else begin
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      ph_q   <= ph_d;
      y_q    <= y_d;
    end
  end

  assign y    = y_q;
  assign busy = pend_q;

endmodule

// File: rtl/gf180mcu_osu_sc_9t_clkdiv_bank.sv
// Bank of independent even-ratio clock dividers sharing one config bus.
// Only the handshake decode lives here; all state is in the channels.
module gf180mcu_osu_sc_9t_clkdiv_bank
  import gf180mcu_osu_sc_9t_clkdiv_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int DIV_W = 8
) (
  input  logic                          CLK,
  input  logic                          RN,
  input  logic                          CFG_VLD,
  output logic                          CFG_RDY,
  input  logic [ch_sel_w(N_CH)-1:0]     CFG_CH,
  input  logic [DIV_W-1:0]              CFG_DIV,
  input  logic                          CFG_INV,
  input  logic                          CFG_EN,
  output logic [N_CH-1:0]               Y,
  output logic [N_CH-1:0]               BUSY
);

  logic [3:0]        ch_idx;
  logic              ch_ok;
  logic [MAX_CH-1:0] busy_ext;

  assign ch_idx   = 4'(CFG_CH);
  assign ch_ok    = ({1'b0, ch_idx} < 5'(N_CH));
  assign busy_ext = MAX_CH'(BUSY);
  // Requests to non-existent channels are always accepted and dropped.
  assign CFG_RDY  = ~ch_ok | ~busy_ext[ch_idx];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic ch_wr;
    assign ch_wr = CFG_VLD & CFG_RDY & ch_ok & (ch_idx == 4'(i));

    gf180mcu_osu_sc_9t_clkdiv_ch #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk    (CLK),
      .rn     (RN),
      .wr     (ch_wr),
      .wr_div (CFG_DIV),
      .wr_inv (CFG_INV),
      .wr_en  (CFG_EN),
      .y      (Y[i]),
      .busy   (BUSY[i])
    );
  end

endmodule
